// File: rtl/vga_scan_out_if.sv
// rtl/vga_scan_out_if.sv - pixel-coordinate bus and VGA pin bundle for vga_scan_out
//
// Purpose: groups the signals exchanged between the scan-out block, the colour
//          layers and the display pins.
// Signals:
//   rgb_in      mixed 4-bit palette colour from the layer mixer (gbgr, 0 = black)
//   pix_stb     one-clk pulse per pixel
//   pix_x/pix_y current raster coordinate
//   pix_active  coordinate lies in the visible area
//   frame_start pulse at the strobe of pixel (0,0)
//   line_start  pulse at the strobe of pixel x=0
//   vga_rgb     blanked colour to the DAC
//   vga_hs/vs   active-low sync pins
// Modports: master = scan-out block, slave = layers / display side.
interface vga_scan_out_if;
  logic [3:0] rgb_in;
  logic       pix_stb;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_active;
  logic       frame_start;
  logic       line_start;
  logic [3:0] vga_rgb;
  logic       vga_hs;
  logic       vga_vs;

  modport master (
    input  rgb_in,
    output pix_stb, pix_x, pix_y, pix_active, frame_start, line_start,
    output vga_rgb, vga_hs, vga_vs
  );

  modport slave (
    output rgb_in,
    input  pix_stb, pix_x, pix_y, pix_active, frame_start, line_start,
    input  vga_rgb, vga_hs, vga_vs
  );
endinterface

// File: rtl/vga_scan_out.sv
// rtl/vga_scan_out.sv - VGA raster timing generator and aligned colour/sync output stage
//
// Purpose: divides clk down to a pixel strobe, runs the h/v raster counters,
//          publishes the current coordinate to the colour layers and drives
//          blanked colour plus hsync/vsync after the colour pipeline latency.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   vga    vga_scan_out_if.master: rgb_in in; pix_* coordinate bus and
//          vga_rgb/vga_hs/vga_vs pins out
module vga_scan_out #(
  parameter int PIX_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_scan_out_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic          stb_q;
  logic          run_q;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic [3:0]    rgb_q;
  logic          hs_q;
  logic          vs_q;

  // Sideband terms for the current coordinate: {active, hs_raw, vs_raw}.
  logic          active_raw;
  logic          hs_raw;
  logic          vs_raw;
  logic [2:0]    raw_t;
  logic [2:0]    dly_t;

  always_comb begin
    div_d = div_q + 1'b1;
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end
  end

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (stb_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_comb begin
    active_raw = (h_q < H_ACT) && (v_q < V_ACT);
    hs_raw     = !((h_q >= HS_BEG) && (h_q < HS_END));
    vs_raw     = !((v_q >= VS_BEG) && (v_q < VS_END));
    raw_t      = {active_raw, hs_raw, vs_raw};
  end

  // The strobe is registered so it is a clean 0 while in reset; it first rises
  // PIX_DIV clocks after release and then every PIX_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      stb_q <= 1'b0;
      run_q <= 1'b0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      stb_q <= (div_q == DIV_LAST);
      run_q <= 1'b1;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  // Sideband delay line matching the colour layers' pipeline depth, so that
  // blanking and sync line up with the colour that arrives for the same pixel.
  generate
    if (PIPE_LAT == 0) begin : g_direct
      assign dly_t = raw_t;
    end else begin : g_pipe
      logic [2:0] pipe_q [PIPE_LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_LAT; i++) begin
            pipe_q[i] <= 3'b011;
          end
        end else if (stb_q) begin
          pipe_q[0] <= raw_t;
          for (int i = 1; i < PIPE_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
        end
      end

      assign dly_t = pipe_q[PIPE_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= 4'd0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (stb_q) begin
      rgb_q <= dly_t[2] ? vga.rgb_in : 4'd0;
      hs_q  <= dly_t[1];
      vs_q  <= dly_t[0];
    end
  end

  assign vga.pix_stb     = stb_q;
  assign vga.pix_x       = h_q;
  assign vga.pix_y       = v_q;
  // run_q keeps pix_active low while reset is held, when the counters sit at (0,0).
  assign vga.pix_active  = run_q & active_raw;
  assign vga.line_start  = stb_q & (h_q == 10'd0);
  assign vga.frame_start = stb_q & (h_q == 10'd0) & (v_q == 10'd0);
  assign vga.vga_rgb     = rgb_q;
  assign vga.vga_hs      = hs_q;
  assign vga.vga_vs      = vs_q;

endmodule

// File: tb/tb_vga_scan_out.sv
// tb/tb_vga_scan_out.sv - self-checking bench for vga_scan_out with a raster reference model
module tb_vga_scan_out;

  localparam int HA = 16, HFP = 4, HSY = 6, HBP = 4;
  localparam int VA = 8,  VFP = 2, VSY = 2, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;   // 30
  localparam int VT = VA + VFP + VSY + VBP;   // 15
  localparam int FRAME = HT * VT;             // 450
  localparam int HIST = 8192;

  localparam int DIV_A = 2, LAT_A = 2;
  localparam int DIV_B = 1, LAT_B = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_scan_out_if if_a ();
  vga_scan_out_if if_b ();

  vga_scan_out #(
    .PIX_DIV(DIV_A), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .PIPE_LAT(LAT_A)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .vga(if_a.master)
  );

  vga_scan_out #(
    .PIX_DIV(DIV_B), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .PIPE_LAT(LAT_B)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .vga(if_b.master)
  );

  int checks = 0;
  int errors = 0;

  int c_cnt [2];
  int n_cnt [2];
  int first_stb_c [2];
  logic [3:0] hist [2][HIST];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic bit in_active(input int x, input int y);
    return (x < HA) && (y < VA);
  endfunction

  // One negedge worth of checking for one DUT; returns the rgb_in to drive next.
  task automatic check_dut(input int id, input int pdiv, input int lat,
                           input logic stb, input logic [9:0] x, input logic [9:0] y,
                           input logic act, input logic fs, input logic ls,
                           input logic [3:0] rgb, input logic hs, input logic vs,
                           output logic [3:0] drv);
    string p;
    int n, ex, ey, m, mx, my, cx, cy;
    bit exp_stb;
    p = (id == 0) ? "A_" : "B_";
    drv = 4'($urandom);
    if (!rst_n) begin
      c_cnt[id] = 0;
      n_cnt[id] = 0;
      chk({p, "rst_stb"}, int'(stb), 0);
      chk({p, "rst_xy"}, int'({x, y}), 0);
      chk({p, "rst_flags"}, int'({act, fs, ls}), 0);
      chk({p, "rst_pins"}, int'({rgb, hs, vs}), 3);
      return;
    end
    c_cnt[id]++;
    exp_stb = (c_cnt[id] % pdiv) == 0;
    chk({p, "pix_stb"}, int'(stb), int'(exp_stb));
    if (stb && first_stb_c[id] < 0) first_stb_c[id] = c_cnt[id];
    if (!(stb && exp_stb)) return;
    n = n_cnt[id];
    if (n >= HIST) $fatal(1, "FAIL %shist_overflow: got %0d expected below %0d", p, n, HIST);
    ex = n % HT;
    ey = (n / HT) % VT;
    chk({p, "pix_x"}, int'(x), ex);
    chk({p, "pix_y"}, int'(y), ey);
    chk({p, "pix_active"}, int'(act), int'(in_active(ex, ey)));
    chk({p, "frame_start"}, int'(fs), int'(ex == 0 && ey == 0));
    chk({p, "line_start"}, int'(ls), int'(ex == 0));
    if (n < lat + 1) begin
      chk({p, "vga_rgb"}, int'(rgb), 0);
      chk({p, "vga_hs"}, int'(hs), 1);
      chk({p, "vga_vs"}, int'(vs), 1);
    end else begin
      m = n - lat - 1;
      mx = m % HT;
      my = (m / HT) % VT;
      chk({p, "vga_hs"}, int'(hs), int'(!(mx >= HA + HFP && mx < HA + HFP + HSY)));
      chk({p, "vga_vs"}, int'(vs), int'(!(my >= VA + VFP && my < VA + VFP + VSY)));
      chk({p, "vga_rgb"}, int'(rgb), in_active(mx, my) ? int'(hist[id][m + lat]) : 0);
    end
    // Colour presented at strobe n belongs to coordinate n-lat; blanked
    // coordinates get 4'hF so leakage through blanking shows up.
    if (n >= lat) begin
      cx = (n - lat) % HT;
      cy = ((n - lat) / HT) % VT;
      if (!in_active(cx, cy)) drv = 4'hF;
    end else begin
      drv = 4'hF;
    end
    hist[id][n] = drv;
    n_cnt[id]++;
  endtask

  task automatic cycle();
    logic [3:0] da, db;
    check_dut(0, DIV_A, LAT_A, if_a.pix_stb, if_a.pix_x, if_a.pix_y, if_a.pix_active,
              if_a.frame_start, if_a.line_start, if_a.vga_rgb, if_a.vga_hs, if_a.vga_vs, da);
    check_dut(1, DIV_B, LAT_B, if_b.pix_stb, if_b.pix_x, if_b.pix_y, if_b.pix_active,
              if_b.frame_start, if_b.line_start, if_b.vga_rgb, if_b.vga_hs, if_b.vga_vs, db);
    if_a.rgb_in = da;
    if_b.rgb_in = db;
  endtask

  int first_hs_low_a, vs_low_a, ls_a, fs_a, hs_low_b, idx;
  bit found;

  initial begin
    if_a.rgb_in = 4'h0;
    if_b.rgb_in = 4'h0;
    first_stb_c[0] = -1;
    first_stb_c[1] = -1;
    first_hs_low_a = -1;
    vs_low_a = 0; ls_a = 0; fs_a = 0; hs_low_b = 0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cycle();
    end
    rst_n = 1'b1;

    // Two-plus frames of free running; collect hand-checkable pins on the side.
    for (int i = 0; i < 2 * FRAME * DIV_A + 200; i++) begin
      @(negedge clk);
      cycle();
      if (if_a.pix_stb) begin
        idx = n_cnt[0] - 1;
        if (!if_a.vga_hs && first_hs_low_a < 0) first_hs_low_a = idx;
        if (!if_a.vga_vs && idx >= LAT_A + 1 && idx < LAT_A + 1 + FRAME) vs_low_a++;
        if (if_a.line_start && idx < FRAME) ls_a++;
        if (if_a.frame_start && idx < 2 * FRAME) fs_a++;
      end
      if (if_b.pix_stb) begin
        idx = n_cnt[1] - 1;
        if (!if_b.vga_hs && idx >= LAT_B + 1 && idx < LAT_B + 1 + HT) hs_low_b++;
      end
    end

    chk("A_first_stb_clk", first_stb_c[0], 2);
    chk("B_first_stb_clk", first_stb_c[1], 1);
    chk("A_first_hs_low_strobe", first_hs_low_a, 23);
    chk("A_vs_low_strobes", vs_low_a, 60);
    chk("A_line_starts_per_frame", ls_a, 15);
    chk("A_frame_starts", fs_a, 2);
    chk("B_hs_low_clks", hs_low_b, 6);

    // Mid-line reset while DUT A sits on an active pixel.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME * DIV_A && !found; i++) begin
      @(negedge clk);
      cycle();
      if (if_a.pix_stb && if_a.pix_x == 10'd10 && if_a.pix_y == 10'd5) found = 1'b1;
    end
    chk("A_reset_point_found", int'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("A_async_rst_xy", int'({if_a.pix_x, if_a.pix_y}), 0);
    chk("A_async_rst_pins", int'({if_a.vga_rgb, if_a.vga_hs, if_a.vga_vs}), 3);
    chk("A_async_rst_stb", int'(if_a.pix_stb), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cycle();
    end
    rst_n = 1'b1;
    first_stb_c[0] = -1;
    fs_a = 0;
    for (int i = 0; i < FRAME * DIV_A + 100; i++) begin
      @(negedge clk);
      cycle();
      if (if_a.pix_stb && if_a.frame_start && fs_a == 0) begin
        fs_a = 1;
        chk("A_restart_frame_strobe_index", n_cnt[0] - 1, 0);
      end
    end
    chk("A_restart_first_stb_clk", first_stb_c[0], 2);
    chk("A_restart_frame_seen", fs_a, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
